// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg
// Shared definitions for the MISC-V immediate generator slice.
// Contents:
//   OP_R..OP_J1  3-bit opcodes found in instr[2:0]
//   FMT_W        width of the format tag
//   FMT_R..FMT_J format tag codes carried alongside each immediate
package imm_gen_pkg;

  localparam logic [2:0] OP_R  = 3'b000;
  localparam logic [2:0] OP_I  = 3'b001;
  localparam logic [2:0] OP_M0 = 3'b010;
  localparam logic [2:0] OP_M1 = 3'b011;
  localparam logic [2:0] OP_Y0 = 3'b100;
  localparam logic [2:0] OP_Y1 = 3'b101;
  localparam logic [2:0] OP_J0 = 3'b110;
  localparam logic [2:0] OP_J1 = 3'b111;

  localparam int FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_R = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I = 3'd1;
  localparam logic [FMT_W-1:0] FMT_M = 3'd2;
  localparam logic [FMT_W-1:0] FMT_Y = 3'd3;
  localparam logic [FMT_W-1:0] FMT_J = 3'd4;

endpackage

// File: rtl/imm_gen_decode.sv
// imm_gen_decode
// Purely combinational immediate extraction for 16-bit MISC-V instructions.
// Parameters:
//   XLEN  width of the sign-extended immediate (>= 16)
// Ports:
//   instr  in   16     instruction word, opcode in instr[2:0]
//   imm    out  XLEN   sign-extended immediate
//   fmt    out  FMT_W  format tag (FMT_R/I/M/Y/J)
module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic [15:0]      instr,
  output logic [XLEN-1:0]  imm,
  output logic [FMT_W-1:0] fmt
);

  // Select the immediate field for the opcode and sign-extend it from the
  // top bit of the concatenated field. Y and J fields are halfword offsets,
  // so a zero is appended as the LSB before extension.
  always_comb begin
    imm = '0;
    fmt = FMT_R;
    case (instr[2:0])
      OP_R: begin
        imm = '0;
        fmt = FMT_R;
      end
      OP_I: begin
        imm = {{(XLEN-5){instr[13]}}, instr[13:9]};
        fmt = FMT_I;
      end
      OP_M0, OP_M1: begin
        imm = {{(XLEN-7){instr[15]}}, instr[15:9]};
        fmt = FMT_M;
      end
      OP_Y0, OP_Y1: begin
        imm = {{(XLEN-8){instr[15]}}, instr[15:12], instr[5:3], 1'b0};
        fmt = FMT_Y;
      end
      OP_J0, OP_J1: begin
        imm = {{(XLEN-11){instr[15]}}, instr[15:6], 1'b0};
        fmt = FMT_J;
      end
      default: begin
        imm = '0;
        fmt = FMT_R;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Pipelined immediate generator sitting between fetch and decode/execute.
// Decoded immediates are buffered in a DEPTH-entry FIFO with a flush for
// branch redirects. Optional feature macro: IMM_GEN_TARGET_EN adds in_pc and
// out_target (pc + imm for Y/J formats, pc otherwise), stored per entry.
// Parameters:
//   XLEN   immediate / pc width (>= 16)
//   DEPTH  FIFO entries (power of 2, >= 2)
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   flush                 drop all buffered entries and any same-cycle push
//   in_valid/in_ready     instruction handshake, in_instr the instruction word
//   out_valid/out_ready   result handshake, out_imm/out_fmt the head entry
//   in_pc/out_target      only with IMM_GEN_TARGET_EN
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt
`ifdef IMM_GEN_TARGET_EN
  ,
  input  logic [XLEN-1:0]  in_pc,
  output logic [XLEN-1:0]  out_target
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  logic [XLEN-1:0]  dec_imm;
  logic [FMT_W-1:0] dec_fmt;

  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic [FMT_W-1:0] fmt_mem [DEPTH];
  logic [XLEN-1:0]  hold_imm;
  logic [FMT_W-1:0] hold_fmt;

  imm_gen_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr(in_instr),
    .imm  (dec_imm),
    .fmt  (dec_fmt)
  );

  // in_ready depends only on the occupancy, so a full FIFO refuses a push
  // even when the consumer pops in the same cycle.
  assign in_ready  = (count < DEPTH_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because DEPTH
  // is a power of two. Flush empties the FIFO and overrides any push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. A push never lands on the head slot while the FIFO holds
  // data, so the head stays stable during back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem[i] <= '0;
        fmt_mem[i] <= FMT_R;
      end
    end else if (push && !flush) begin
      imm_mem[wr_ptr] <= dec_imm;
      fmt_mem[wr_ptr] <= dec_fmt;
    end
  end

  // Shadow of the most recently presented head, so the outputs keep their
  // last value once the FIFO drains or is flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_imm <= '0;
      hold_fmt <= FMT_R;
    end else if (out_valid) begin
      hold_imm <= imm_mem[rd_ptr];
      hold_fmt <= fmt_mem[rd_ptr];
    end
  end

  assign out_imm = out_valid ? imm_mem[rd_ptr] : hold_imm;
  assign out_fmt = out_valid ? fmt_mem[rd_ptr] : hold_fmt;

`ifdef IMM_GEN_TARGET_EN
  logic [XLEN-1:0] dec_target;
  logic [XLEN-1:0] target_mem [DEPTH];
  logic [XLEN-1:0] hold_target;

  // Only PC-relative formats (Y, J) add the offset; others pass the pc.
  assign dec_target = ((dec_fmt == FMT_Y) || (dec_fmt == FMT_J)) ? (in_pc + dec_imm) : in_pc;

  // Target storage follows the same write and hold rules as the immediate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        target_mem[i] <= '0;
      end
      hold_target <= '0;
    end else begin
      if (push && !flush) target_mem[wr_ptr] <= dec_target;
      if (out_valid) hold_target <= target_mem[rd_ptr];
    end
  end

  assign out_target = out_valid ? target_mem[rd_ptr] : hold_target;
`else
  // Without the target option only the immediate and format are buffered.
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
// Self-checking bench for imm_gen_pipe at XLEN=16, DEPTH=2. A queue-based
// reference model tracks FIFO contents and decodes immediates arithmetically.
// With IMM_GEN_TARGET_EN defined the target path is exercised as well.
module tb_imm_gen_pipe;

  localparam int XLEN  = 16;
  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [2:0]  out_fmt;
`ifdef IMM_GEN_TARGET_EN
  logic [15:0] in_pc;
  logic [15:0] out_target;
`endif

  int checks = 0;
  int fails  = 0;

  logic [15:0] mq[$];

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  vec_t vecs[9];

  imm_gen_pipe #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .out_fmt  (out_fmt)
`ifdef IMM_GEN_TARGET_EN
    ,
    .in_pc     (in_pc),
    .out_target(out_target)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode: pull the field out with shifts/modulo, then
  // convert to a signed value by subtracting 2^width when the top bit is set.
  function automatic logic [15:0] ref_imm(input logic [15:0] instr);
    int w;
    int v;
    w = int'(instr);
    case (w % 8)
      1: begin
        v = (w / 512) % 32;
        if (v >= 16) v -= 32;
      end
      2, 3: begin
        v = (w / 512) % 128;
        if (v >= 64) v -= 128;
      end
      4, 5: begin
        v = ((w / 4096) % 16) * 16 + ((w / 8) % 8) * 2;
        if (v >= 128) v -= 256;
      end
      6, 7: begin
        v = ((w / 64) % 1024) * 2;
        if (v >= 1024) v -= 2048;
      end
      default: v = 0;
    endcase
    return v[15:0];
  endfunction

  function automatic logic [2:0] ref_fmt(input logic [15:0] instr);
    case (int'(instr) % 8)
      1:       return 3'd1;
      2, 3:    return 3'd2;
      4, 5:    return 3'd3;
      6, 7:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // One comparison: count it, and report a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the clock edge,
  // then compare the DUT against the model just after the edge.
  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic rdy, input logic fl);
    int pre;
    in_valid  = v;
    in_instr  = instr;
    out_ready = rdy;
    flush     = fl;
    pre = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      if (pre > 0 && rdy) void'(mq.pop_front());
      if (v && pre < DEPTH) mq.push_back(instr);
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    checkOutput("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    if (mq.size() > 0) begin
      checkOutput("head_imm", 32'(out_imm), 32'(ref_imm(mq[0])));
      checkOutput("head_fmt", 32'(out_fmt), 32'(ref_fmt(mq[0])));
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
`ifdef IMM_GEN_TARGET_EN
    in_pc     = 16'h0100;
`endif

    vecs[0] = '{16'h3E01, 16'hFFFF, 3'd1};
    vecs[1] = '{16'h7E02, 16'h003F, 3'd2};
    vecs[2] = '{16'h8004, 16'hFF80, 3'd3};
    vecs[3] = '{16'hFFC6, 16'hFFFE, 3'd4};
    vecs[4] = '{16'h0000, 16'h0000, 3'd0};
    vecs[5] = '{16'h8002, 16'hFFC0, 3'd2};
    vecs[6] = '{16'h703D, 16'h007E, 3'd3};
    vecs[7] = '{16'h0047, 16'h0002, 3'd4};
    vecs[8] = '{16'hFFF8, 16'h0000, 3'd0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_imm", 32'(out_imm), 32'd0);
    checkOutput("rst_out_fmt", 32'(out_fmt), 32'd0);
`ifdef IMM_GEN_TARGET_EN
    checkOutput("rst_out_target", 32'(out_target), 32'd0);
`endif
    reset = 1'b0;

    // Table of known encodings, one per cycle, visible the cycle after push.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vecs[i].instr, 1'b1, 1'b0);
      checkOutput("tbl_valid", 32'(out_valid), 32'd1);
      checkOutput("tbl_imm", 32'(out_imm), 32'(vecs[i].imm));
      checkOutput("tbl_fmt", 32'(out_fmt), 32'(vecs[i].fmt));
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Back-pressure: third push is refused while full, even during a pop.
    applyStimulus(1'b1, 16'h3E01, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h7E02, 1'b0, 1'b0);
    checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 16'h8004, 1'b0, 1'b0);
    checkOutput("bp_stall_head", 32'(out_imm), 32'hFFFF);
    applyStimulus(1'b1, 16'h8004, 1'b1, 1'b0);
    checkOutput("bp_second", 32'(out_imm), 32'h003F);
    applyStimulus(1'b1, 16'h8004, 1'b1, 1'b0);
    checkOutput("bp_third", 32'(out_imm), 32'hFF80);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("bp_drained", 32'(out_valid), 32'd0);

    // Full-rate random stream.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 16'($urandom), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random handshakes with occasional flush.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 16'($urandom),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    // Flush with two buffered entries and a same-cycle push.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h3E01, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h7E02, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFFC6, 1'b1, 1'b1);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("flush_gone", 32'(out_valid), 32'd0);

    // Asynchronous reset between clock edges.
    applyStimulus(1'b1, 16'h7E02, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_ready", 32'(in_ready), 32'd1);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 16'hFFC6, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

`ifdef IMM_GEN_TARGET_EN
    // Branch target from pc 0x0100 and a Y-format offset of -128.
    in_pc = 16'h0100;
    applyStimulus(1'b1, 16'h8004, 1'b0, 1'b0);
    checkOutput("target_y", 32'(out_target), 32'h0080);
    applyStimulus(1'b1, 16'h3E01, 1'b1, 1'b0);
    checkOutput("target_i", 32'(out_target), 32'h0100);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
